// File: rtl/aes_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// Module : aes_ctrl_pkg
// Brief  : Shared types and constants for the AES core sharing controller.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package aes_ctrl_pkg;

  localparam int AES_BLK_W        = 128;
  localparam int ABORT_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_ABORT  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Combinational round-robin picker; searches from the slot after ptr.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int             cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    // The last-served slot is visited last, which bounds wait to NUM_REQ jobs.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_core_arbiter.sv
// ----------------------------------------------------------------------------
// Module : aes_core_arbiter
// Brief  : Shares one aes_128 core between NUM_REQ requesters with a watchdog.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_encrypt,
  input  logic [NUM_REQ*128-1:0]     req_data,
  input  logic [NUM_REQ*128-1:0]     req_key,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [127:0]               rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_timeout,
  output logic                       core_start,
  output logic                       core_encrypt,
  output logic [127:0]               core_text,
  output logic [127:0]               core_key,
  output logic                       core_rst,
  input  logic [127:0]               core_ciphertext,
  input  logic                       core_done
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam int AB_W = $clog2(ABORT_RST_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [AB_W-1:0]        ab_cnt_q, ab_cnt_d;
  logic                   core_rst_q, core_rst_d;
  logic                   core_encrypt_q, core_encrypt_d;
  logic [AES_BLK_W-1:0]   core_text_q, core_text_d;
  logic [AES_BLK_W-1:0]   core_key_q, core_key_d;
  logic [AES_BLK_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  logic [NUM_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]        arb_idx;
  logic                   arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    wd_d           = wd_q;
    ab_cnt_d       = ab_cnt_q;
    core_encrypt_d = core_encrypt_q;
    core_text_d    = core_text_q;
    core_key_d     = core_key_q;
    rsp_data_d     = rsp_data_q;
    rsp_id_d       = rsp_id_q;
    rsp_timeout_d  = rsp_timeout_q;
    req_ready      = '0;
    core_start     = 1'b0;
    rsp_valid      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // core_rst_q still set means we are in the first cycle after reset.
        if (arb_any && !core_rst_q) begin
          req_ready      = arb_grant;
          core_encrypt_d = req_encrypt[arb_idx];
          core_text_d    = req_data[arb_idx*AES_BLK_W +: AES_BLK_W];
          core_key_d     = req_key[arb_idx*AES_BLK_W +: AES_BLK_W];
          rsp_id_d       = arb_idx;
          rr_ptr_d       = arb_idx;
          state_d        = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        wd_d       = '0;
        state_d    = S_BUSY;
      end
      S_BUSY: begin
        if (core_done) begin
          rsp_data_d    = core_ciphertext;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          ab_cnt_d      = '0;
          state_d       = S_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ABORT: begin
        if (ab_cnt_q == AB_W'(ABORT_RST_CYCLES - 1)) begin
          state_d = S_RESP;
        end else begin
          ab_cnt_d = ab_cnt_q + AB_W'(1);
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so the core sees a clean reset for exactly the ABORT cycles.
    core_rst_d = (state_d == S_ABORT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= ID_W'(NUM_REQ - 1);
      wd_q           <= '0;
      ab_cnt_q       <= '0;
      core_rst_q     <= 1'b1;
      core_encrypt_q <= 1'b0;
      core_text_q    <= '0;
      core_key_q     <= '0;
      rsp_data_q     <= '0;
      rsp_id_q       <= '0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      wd_q           <= wd_d;
      ab_cnt_q       <= ab_cnt_d;
      core_rst_q     <= core_rst_d;
      core_encrypt_q <= core_encrypt_d;
      core_text_q    <= core_text_d;
      core_key_q     <= core_key_d;
      rsp_data_q     <= rsp_data_d;
      rsp_id_q       <= rsp_id_d;
      rsp_timeout_q  <= rsp_timeout_d;
    end
  end

  assign core_rst     = core_rst_q;
  assign core_encrypt = core_encrypt_q;
  assign core_text    = core_text_q;
  assign core_key     = core_key_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
// ----------------------------------------------------------------------------
// Module : tb_aes_core_arbiter
// Brief  : Directed bench for aes_core_arbiter with a latency-programmable core stub.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_aes_core_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid, req_ready, req_encrypt;
  logic [NUM_REQ*128-1:0] req_data, req_key;
  logic                   rsp_valid, rsp_ready, rsp_timeout;
  logic [127:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   core_start, core_encrypt, core_rst, core_done;
  logic [127:0]           core_text, core_key, core_ciphertext;

  logic                   stub_done, stub_busy, stub_suppress, inject_done;
  logic [127:0]           stub_res;
  int                     stub_cnt, stub_lat;

  int errors = 0;
  int checks = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, done_cyc = 0, accept_cyc = 0;
  int rst_cnt = 0, rise_cyc = 0;
  logic core_rst_prev = 1'b0;
  logic         grant_q[$];
  logic         rspid_q[$];
  logic [127:0] rspdat_q[$];

  always #5 clk = ~clk;

  assign core_done = stub_done | inject_done;

  aes_core_arbiter #(
    .NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(64), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_encrypt(req_encrypt),
    .req_data(req_data), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_timeout(rsp_timeout),
    .core_start(core_start), .core_encrypt(core_encrypt), .core_text(core_text),
    .core_key(core_key), .core_rst(core_rst),
    .core_ciphertext(core_ciphertext), .core_done(core_done)
  );

  // Stand-in for aes_128: known FIPS-197 answers, otherwise a cheap keyed mix.
  function automatic logic [127:0] core_model(input logic enc, input logic [127:0] t,
                                              input logic [127:0] k);
    if (enc && t == PT && k == KEY) return CT;
    if (!enc && t == CT && k == KEY) return PT;
    return t ^ {k[63:0], k[127:64]} ^ {128{enc}};
  endfunction

  always @(posedge clk) begin
    if (core_rst) begin
      stub_busy <= 1'b0;
      stub_done <= 1'b0;
      stub_cnt  <= 0;
    end else begin
      stub_done <= 1'b0;
      if (core_start) begin
        stub_busy <= 1'b1;
        stub_cnt  <= stub_lat;
        stub_res  <= core_model(core_encrypt, core_text, core_key);
      end else if (stub_busy) begin
        if (stub_cnt <= 1) begin
          stub_busy <= 1'b0;
          if (!stub_suppress) begin
            stub_done       <= 1'b1;
            core_ciphertext <= stub_res;
          end
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  // Event recorder; cycle index = value of cyc during that cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (core_done) done_cyc <= cyc;
    if (|(req_valid & req_ready)) begin
      accept_cyc <= cyc;
      grant_q.push_back(req_ready[1]);
    end
    if (rsp_valid && rsp_ready) begin
      rspid_q.push_back(rsp_id);
      rspdat_q.push_back(rsp_data);
    end
    if (core_rst && rst) rst_cnt <= rst_cnt + 1;
    if (core_rst && !core_rst_prev) rise_cyc <= cyc;
    core_rst_prev <= core_rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic submit(input int idx, input logic enc, input logic [127:0] d,
                        input logic [127:0] k);
    int n = 0;
    req_encrypt[idx]         = enc;
    req_data[idx*128 +: 128] = d;
    req_key[idx*128 +: 128]  = k;
    req_valid[idx]           = 1'b1;
    #1;
    while (!req_ready[idx] && n < 100) begin
      step();
      n++;
    end
    check("accept_wait", (n < 100), 1);
    step();
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!rsp_valid && n < 300) begin
      step();
      n++;
    end
    check("rsp_wait", (n < 300), 1);
  endtask

  task automatic take_rsp(input string tag, input logic [127:0] d, input logic id,
                          input logic to);
    check({tag, "_data"}, rsp_data, d);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_timeout"}, rsp_timeout, to);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_released"}, rsp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL tb_watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, base, rbase, s0, r0, viol;
    logic [127:0] cap_d;
    logic         cap_id;
    logic [127:0] d3 [2];
    logic [127:0] k3 [2];

    rst = 1'b0; req_valid = '0; req_encrypt = '0; req_data = '0; req_key = '0;
    rsp_ready = 1'b0; inject_done = 1'b0; stub_lat = 4; stub_suppress = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_text", core_text, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_encrypt", core_encrypt, 0);
    check("rst_core_rst", core_rst, 1);
    rst = 1'b1;
    #1;
    check("rst_core_rst_hold", core_rst, 1);
    step();
    check("rst_core_rst_release", core_rst, 0);

    // 1: FIPS-197 encrypt on req0, with latency checks
    submit(0, 1'b1, PT, KEY);
    step();
    check("t1_start_lat", start_cyc, accept_cyc + 1);
    check("t1_text_latched", core_text, PT);
    wait_valid();
    check("t1_rsp_lat", cyc, done_cyc + 1);
    take_rsp("t1", CT, 1'b0, 1'b0);

    // 2: decrypt on req1
    submit(1, 1'b0, CT, KEY);
    wait_valid();
    take_rsp("t2", PT, 1'b1, 1'b0);

    // 3: both requesters continuously valid for 6 jobs
    stub_lat = 3;
    d3[0] = 128'h0123456789abcdef0011223344556677;
    d3[1] = 128'hfedcba98765432108899aabbccddeeff;
    k3[0] = 128'h11111111222222223333333344444444;
    k3[1] = 128'h55555555666666667777777788888888;
    req_encrypt = 2'b11;
    req_data = {d3[1], d3[0]};
    req_key  = {k3[1], k3[0]};
    base = grant_q.size(); rbase = rspid_q.size(); s0 = start_cnt;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    n = 0;
    while ((grant_q.size() - base) < 6 && n < 500) begin
      step();
      n++;
    end
    req_valid = 2'b00;
    repeat (30) step();
    rsp_ready = 1'b0;
    check("t3_grants", grant_q.size() - base, 6);
    check("t3_starts", start_cnt - s0, 6);
    check("t3_rsps", rspid_q.size() - rbase, 6);
    for (int i = 0; i < 6; i++) begin
      check("t3_grant_order", grant_q[base+i], (i % 2));
      check("t3_rsp_id", rspid_q[rbase+i], (i % 2));
      check("t3_rsp_data", rspdat_q[rbase+i], core_model(1'b1, d3[i%2], k3[i%2]));
    end

    // 4: back-pressure holds the response and blocks new grants
    submit(0, 1'b1, d3[1], k3[0]);
    wait_valid();
    req_encrypt[1] = 1'b0;
    req_data[255:128] = d3[0];
    req_key[255:128]  = k3[1];
    req_valid[1] = 1'b1;
    #1;
    cap_d = rsp_data; cap_id = rsp_id; s0 = start_cnt; viol = 0;
    repeat (20) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_data !== cap_d || rsp_id !== cap_id ||
          rsp_timeout !== 1'b0 || req_ready !== 2'b00 || core_start !== 1'b0)
        viol++;
    end
    check("t4_stall_violations", viol, 0);
    check("t4_no_start", start_cnt - s0, 0);
    take_rsp("t4a", core_model(1'b1, d3[1], k3[0]), 1'b0, 1'b0);
    check("t4_next_grant", req_ready, 2'b10);
    step();
    req_valid[1] = 1'b0;
    wait_valid();
    take_rsp("t4b", core_model(1'b0, d3[0], k3[1]), 1'b1, 1'b0);

    // 5: watchdog timeout, then late done is ignored
    stub_suppress = 1'b1;
    r0 = rst_cnt;
    submit(0, 1'b1, PT, KEY);
    wait_valid();
    check("t5_core_rst_cycles", rst_cnt - r0, 2);
    check("t5_abort_delay", rise_cyc - start_cyc, 65);
    inject_done = 1'b1;
    step();
    inject_done = 1'b0;
    step();
    take_rsp("t5", 128'h0, 1'b0, 1'b1);
    inject_done = 1'b1;
    step();
    inject_done = 1'b0;
    viol = 0;
    repeat (5) begin
      step();
      if (rsp_valid !== 1'b0 || core_start !== 1'b0) viol++;
    end
    check("t5_late_done_ignored", viol, 0);
    stub_suppress = 1'b0;

    // 6: asynchronous reset in BUSY
    stub_lat = 10;
    submit(0, 1'b1, PT, KEY);
    repeat (4) step();
    #2;
    rst = 1'b0;
    #1;
    check("t6_core_rst", core_rst, 1);
    check("t6_core_start", core_start, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_req_ready", req_ready, 0);
    check("t6_core_text", core_text, 0);
    check("t6_core_key", core_key, 0);
    check("t6_core_encrypt", core_encrypt, 0);
    check("t6_rsp_data", rsp_data, 0);
    step();
    step();
    rst = 1'b1;
    step();
    check("t6_core_rst_release", core_rst, 0);
    viol = 0;
    repeat (20) begin
      step();
      if (rsp_valid !== 1'b0) viol++;
    end
    check("t6_no_lost_rsp", viol, 0);
    stub_lat = 6;
    submit(0, 1'b1, PT, KEY);
    wait_valid();
    take_rsp("t6", CT, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
